data_order_pack: RTL and testbench
==================================

DATA_ORDER_PACK -- requirements
Module: data_order_pack

Interface
REQ-001 Parameters: none; geometry is fixed at 8 rows x 45 columns = 360 bits.
REQ-002 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 fs_en  in  1  clock enable; all registers hold when fs_en=0.
REQ-005 byte_vld  in  1  byte_in/order_array/sof valid this enabled cycle.
REQ-006 byte_in  in  8  rotated byte from the interleaver output side.
REQ-007 order_array  in  3  rotation amount 0..7 applied to byte_in by the sender.
REQ-008 sof  in  1  qualified by byte_vld; marks byte_in as column 0 of a new word.
REQ-009 word_vld  out  1  one enabled-cycle pulse: word_data holds a complete word.
REQ-010 word_data  out  360  packed word; row r occupies bits [359-45r : 315-45r].
REQ-011 col_cnt  out  6  next column to be written, 0..44.
REQ-012 drop_err  out  1  one enabled-cycle pulse: a partial word was discarded.

Function
REQ-013 Accepted byte: a rising edge with fs_en=1 and byte_vld=1; all other edges are ignored.
REQ-014 Stage 1 de-rotates: d = byte_in rotated right by order_array, so order_array=1 maps {b6..b0,b7} back to {b7..b0}.
REQ-015 Stage 1 registers d, the target column, and a last flag (column==44), one enabled cycle after acceptance.
REQ-016 Stage 2 writes registered column c into the accumulation buffer: acc[359-45r-c] = d[7-r] for r=0..7.
REQ-017 col_cnt increments by 1 per accepted byte and wraps from 44 to 0; values 45..63 never occur.
REQ-018 On stage 2 of column 44, word_data is loaded with the full buffer including that column, and word_vld=1.
REQ-019 Latency: word_vld asserts on the 2nd enabled edge after the 45th byte is accepted.
REQ-020 word_vld deasserts on the next enabled edge unless another word completes.
REQ-021 word_data holds its value until the next word completes.
REQ-022 With fs_en low, word_vld and drop_err hold their levels.
REQ-023 sof with col_cnt=0: the byte is written to column 0 with no error.
REQ-024 sof with col_cnt!=0: the byte is written to column 0, col_cnt becomes 1, and drop_err pulses in stage 2; the partial buffer is not emitted.
REQ-025 Back-to-back bytes, one per enabled cycle, are sustained indefinitely with no stall; words emit every 45 accepted bytes.
REQ-026 Stage-2 loading of word_data and stage-1 acceptance of the next word's column 0 in the same cycle do not interfere.
REQ-027 Unwritten buffer bits in a word that was restarted by sof retain old contents; they are overwritten before the next emission.

Reset
REQ-028 Reset values: word_vld=0, drop_err=0, word_data=0, col_cnt=0, accumulation buffer=0, stage-1 registers=0.
REQ-029 Reset asserted mid-word discards the partial word; after release, the next accepted byte is column 0.
REQ-030 Reset takes effect independently of fs_en and sys_clk.

Verification
REQ-031 45 bytes 0xFF, order_array=0, fs_en=1 -> word_vld pulses once 2 cycles after the last byte; word_data all ones.
REQ-032 Byte 0x80 at column 0 then 44 bytes 0x00, order_array=0 -> word_data[359]=1 only.
REQ-033 Byte 0x01 with order_array=1 at column 44, other bytes 0x00 -> de-rotated 0x80 gives word_data[315]=1 only.
REQ-034 Random bytes and rotations, fed through the forward column-select/rotate model -> this block reconstructs the original 360-bit word exactly.
REQ-035 sof asserted at column 20 -> drop_err one pulse, no word_vld, next word_vld after 45 more bytes counted from that sof byte.
REQ-036 fs_en toggled 1-in-3, and separately rst_n pulsed low at column 30 -> output identical to the continuous-enable run; after reset col_cnt=0 and no spurious word_vld.

Source files
------------

// File: rtl/data_order_pack.sv
// data_order_pack: de-rotates interleaver bytes and packs them
// column-wise into a 8 x 45 bit word, emitting one word per 45 bytes.
module data_order_pack (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic         fs_en,
   input  logic         byte_vld,
   input  logic [7:0]   byte_in,
   input  logic [2:0]   order_array,
   input  logic         sof,
   output logic         word_vld,
   output logic [359:0] word_data,
   output logic [5:0]   col_cnt,
   output logic         drop_err
);

   localparam int         NCOL     = 45;
   localparam int         NROW     = 8;
   localparam logic [5:0] LAST_COL = 6'd44;

   // column counter
   logic [5:0]   col_cnt_q,   col_cnt_d;

   // stage 1: de-rotated byte plus its placement
   logic         s1_vld_q,    s1_vld_d;
   logic [7:0]   s1_data_q,   s1_data_d;
   logic [5:0]   s1_col_q,    s1_col_d;
   logic         s1_last_q,   s1_last_d;
   logic         s1_drop_q,   s1_drop_d;

   // stage 2: accumulation buffer and outputs
   logic [359:0] acc_q,       acc_d;
   logic [359:0] word_data_q, word_data_d;
   logic         word_vld_q,  word_vld_d;
   logic         drop_err_q,  drop_err_d;

   logic         accept;
   logic [15:0]  rot_w;
   logic [7:0]   derot;
   logic [5:0]   tgt_col;
   logic [359:0] acc_wr;

   assign accept = fs_en & byte_vld;

   // undo the sender's left rotation by rotating right
   always_comb begin
      rot_w = {byte_in, byte_in} >> order_array;
      derot = rot_w[7:0];
   end

   // sof forces the byte into column 0 regardless of the count
   always_comb begin
      tgt_col   = sof ? 6'd0 : col_cnt_q;
      col_cnt_d = col_cnt_q;
      if (accept) begin
         if (sof)
            col_cnt_d = 6'd1;
         else if (col_cnt_q == LAST_COL)
            col_cnt_d = 6'd0;
         else
            col_cnt_d = col_cnt_q + 6'd1;
      end
   end

   // stage 1 capture of the accepted byte
   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_data_d = s1_data_q;
      s1_col_d  = s1_col_q;
      s1_last_d = s1_last_q;
      s1_drop_d = s1_drop_q;
      if (fs_en) begin
         s1_vld_d = byte_vld;
         if (byte_vld) begin
            s1_data_d = derot;
            s1_col_d  = tgt_col;
            s1_last_d = (tgt_col == LAST_COL);
            s1_drop_d = sof && (col_cnt_q != 6'd0);
         end
      end
   end

   // buffer image with the stage-1 column merged in
   always_comb begin
      acc_wr = acc_q;
      if (s1_vld_q) begin
         for (int c = 0; c < NCOL; c++) begin
            if (s1_col_q == 6'(c)) begin
               for (int r = 0; r < NROW; r++) begin
                  acc_wr[359 - 45*r - c] = s1_data_q[7 - r];
               end
            end
         end
      end
   end

   // stage 2 buffer update, word emission and drop flag
   always_comb begin
      acc_d       = acc_q;
      word_data_d = word_data_q;
      word_vld_d  = word_vld_q;
      drop_err_d  = drop_err_q;
      if (fs_en) begin
         acc_d      = acc_wr;
         word_vld_d = s1_vld_q & s1_last_q;
         drop_err_d = s1_vld_q & s1_drop_q;
         if (s1_vld_q && s1_last_q)
            word_data_d = acc_wr;
      end
   end

   // all state registers
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt_q   <= '0;
         s1_vld_q    <= 1'b0;
         s1_data_q   <= '0;
         s1_col_q    <= '0;
         s1_last_q   <= 1'b0;
         s1_drop_q   <= 1'b0;
         acc_q       <= '0;
         word_data_q <= '0;
         word_vld_q  <= 1'b0;
         drop_err_q  <= 1'b0;
      end else begin
         col_cnt_q   <= col_cnt_d;
         s1_vld_q    <= s1_vld_d;
         s1_data_q   <= s1_data_d;
         s1_col_q    <= s1_col_d;
         s1_last_q   <= s1_last_d;
         s1_drop_q   <= s1_drop_d;
         acc_q       <= acc_d;
         word_data_q <= word_data_d;
         word_vld_q  <= word_vld_d;
         drop_err_q  <= drop_err_d;
      end
   end

   assign col_cnt   = col_cnt_q;
   assign word_vld  = word_vld_q;
   assign word_data = word_data_q;
   assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_data_order_pack.sv
// tb_data_order_pack: directed bench for data_order_pack.
// Sender side is modelled by column select plus left rotation.
module tb_data_order_pack;

   logic         sys_clk = 1'b0;
   logic         rst_n;
   logic         fs_en;
   logic         byte_vld;
   logic [7:0]   byte_in;
   logic [2:0]   order_array;
   logic         sof;
   logic         word_vld;
   logic [359:0] word_data;
   logic [5:0]   col_cnt;
   logic         drop_err;

   int tests = 0;
   int fails = 0;
   int vld_cnt = 0;
   int drop_cnt = 0;
   logic en_last = 1'b0;

   data_order_pack dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .fs_en       (fs_en),
      .byte_vld    (byte_vld),
      .byte_in     (byte_in),
      .order_array (order_array),
      .sof         (sof),
      .word_vld    (word_vld),
      .word_data   (word_data),
      .col_cnt     (col_cnt),
      .drop_err    (drop_err)
   );

   always #5 sys_clk = ~sys_clk;

   // count enabled-cycle pulses of the two strobes
   always @(posedge sys_clk) en_last <= fs_en;
   always @(negedge sys_clk) begin
      if (rst_n && en_last && word_vld) vld_cnt++;
      if (rst_n && en_last && drop_err) drop_cnt++;
   end

   task automatic check(input string tag, input logic [359:0] obs,
                        input logic [359:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fwd(input logic [359:0] w, input int c,
                                      input int o);
      logic [7:0] ob;
      logic [7:0] sb;
      int j;
      for (int r = 0; r < 8; r++) ob[7-r] = w[359 - 45*r - c];
      for (int i = 0; i < 8; i++) begin
         j = (i + o) % 8;
         sb[j] = ob[i];
      end
      return sb;
   endfunction

   function automatic logic [359:0] rand_word();
      logic [359:0] w = '0;
      for (int k = 0; k < 12; k++) w = (w << 32) | 360'($urandom);
      return w;
   endfunction

   task automatic push(input logic [7:0] b, input logic [2:0] o,
                       input logic s);
      byte_in = b; order_array = o; sof = s;
      byte_vld = 1'b1; fs_en = 1'b1;
      @(posedge sys_clk); #1;
      byte_vld = 1'b0; sof = 1'b0;
   endtask

   task automatic push_slow(input logic [7:0] b, input logic [2:0] o);
      byte_in = b; order_array = o; sof = 1'b0;
      byte_vld = 1'b1; fs_en = 1'b0;
      @(posedge sys_clk); @(posedge sys_clk); #1;
      fs_en = 1'b1;
      @(posedge sys_clk); #1;
      byte_vld = 1'b0; fs_en = 1'b0;
   endtask

   task automatic idle();
      byte_vld = 1'b0; sof = 1'b0; fs_en = 1'b1;
      @(posedge sys_clk); #1;
   endtask

   task automatic hold(input int n);
      byte_vld = 1'b0; fs_en = 1'b0;
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic push_cols(input logic [359:0] w, input int first,
                            input bit slow, input bit sof_first);
      logic [2:0] o;
      for (int c = first; c < 45; c++) begin
         o = 3'($urandom_range(7, 0));
         if (slow) push_slow(fwd(w, c, int'(o)), o);
         else push(fwd(w, c, int'(o)), o, sof_first && (c == first));
      end
   endtask

   logic [359:0] w_rand;
   logic [359:0] w2;
   logic [359:0] ones;
   int v0;
   int d0;

   initial begin
      rst_n = 1'b0; fs_en = 1'b0; byte_vld = 1'b0;
      byte_in = '0; order_array = '0; sof = 1'b0;
      ones = '1;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_word_vld", 360'(word_vld), 360'(0));
      check("rst_drop_err", 360'(drop_err), 360'(0));
      check("rst_word_data", word_data, 360'(0));
      check("rst_col_cnt", 360'(col_cnt), 360'(0));
      @(negedge sys_clk); rst_n = 1'b1;
      @(posedge sys_clk); #1;

      // all ones word, then back-to-back start of the next word
      for (int i = 0; i < 45; i++) begin
         push(8'hFF, 3'd0, 1'b0);
         if (i == 19) check("cnt_20", 360'(col_cnt), 360'(20));
      end
      check("cnt_wrap", 360'(col_cnt), 360'(0));
      check("ones_vld_early", 360'(word_vld), 360'(0));
      push(8'h80, 3'd0, 1'b0);
      check("ones_vld", 360'(word_vld), 360'(1));
      check("ones_data", word_data, ones);
      check("b2b_cnt", 360'(col_cnt), 360'(1));
      push(8'h00, 3'd0, 1'b0);
      check("ones_vld_drop", 360'(word_vld), 360'(0));
      check("ones_hold", word_data, ones);
      for (int i = 0; i < 43; i++) push(8'h00, 3'd0, 1'b0);
      idle();
      check("msb_vld", 360'(word_vld), 360'(1));
      check("msb_data", word_data, 360'(1) << 359);
      idle();
      check("vld_cnt_2", 360'(vld_cnt), 360'(2));

      // single rotated byte in the last column
      for (int i = 0; i < 44; i++) push(8'h00, 3'd0, 1'b0);
      push(8'h01, 3'd1, 1'b0);
      idle();
      check("col44_data", word_data, 360'(1) << 315);

      // random word through the forward model
      w_rand = rand_word();
      push_cols(w_rand, 0, 1'b0, 1'b0);
      idle();
      check("rand_vld", 360'(word_vld), 360'(1));
      check("rand_data", word_data, w_rand);
      idle();

      // sof restart at column 20
      w2 = rand_word();
      v0 = vld_cnt; d0 = drop_cnt;
      for (int i = 0; i < 20; i++) push(8'($urandom), 3'd0, 1'b0);
      check("pre_sof_cnt", 360'(col_cnt), 360'(20));
      push(fwd(w2, 0, 3), 3'd3, 1'b1);
      check("sof_cnt", 360'(col_cnt), 360'(1));
      push(fwd(w2, 1, 0), 3'd0, 1'b0);
      check("sof_drop", 360'(drop_err), 360'(1));
      check("sof_no_vld", 360'(word_vld), 360'(0));
      push(fwd(w2, 2, 5), 3'd5, 1'b0);
      check("sof_drop_clr", 360'(drop_err), 360'(0));
      push_cols(w2, 3, 1'b0, 1'b0);
      idle();
      check("sof_word", word_data, w2);
      idle();
      check("sof_vld_cnt", 360'(vld_cnt - v0), 360'(1));
      check("sof_drop_cnt", 360'(drop_cnt - d0), 360'(1));

      // 1-in-3 enable, same word as the continuous run
      v0 = vld_cnt;
      push_cols(w_rand, 0, 1'b1, 1'b0);
      check("slow_vld_early", 360'(word_vld), 360'(0));
      hold(2);
      check("slow_vld_wait", 360'(word_vld), 360'(0));
      idle();
      check("slow_vld", 360'(word_vld), 360'(1));
      check("slow_data", word_data, w_rand);
      hold(2);
      check("slow_vld_hold", 360'(word_vld), 360'(1));
      idle();
      check("slow_vld_clr", 360'(word_vld), 360'(0));
      idle();
      check("slow_vld_cnt", 360'(vld_cnt - v0), 360'(1));

      // asynchronous reset at column 30
      for (int i = 0; i < 30; i++) push(8'($urandom), 3'd0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_cnt", 360'(col_cnt), 360'(0));
      check("mid_rst_data", word_data, 360'(0));
      @(negedge sys_clk); rst_n = 1'b1;
      v0 = vld_cnt; d0 = drop_cnt;
      idle();
      push_cols(w_rand, 0, 1'b0, 1'b1);
      idle();
      check("post_rst_data", word_data, w_rand);
      idle();
      check("post_rst_vld_cnt", 360'(vld_cnt - v0), 360'(1));
      check("sof_col0_no_drop", 360'(drop_cnt - d0), 360'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
